// File: rtl/lpc_pkg.sv
// Shared constants, FSM state type and output saturation helper for the LPC synthesis stage.
package lpc_pkg;
    localparam int ORDER  = 10;
    localparam int DATA_W = 16;
    localparam int FRAC   = 12;
    localparam int ACC_W  = 40;
    localparam int K_W    = 4;

    // Right-shift Fibonacci form of taps 16,14,13,11: feedback = bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    localparam logic signed [DATA_W-1:0] SAT_MAX     = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN     = 16'sh8000;
    localparam logic signed [ACC_W-1:0]  SAT_MAX_ACC = 40'sd32767;
    localparam logic signed [ACC_W-1:0]  SAT_MIN_ACC = -40'sd32768;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

    // Floor-shift out of the fixed-point domain and clamp to the sample range.
    function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        s = acc >>> FRAC;
        if (s > SAT_MAX_ACC)
            return SAT_MAX;
        else if (s < SAT_MIN_ACC)
            return SAT_MIN;
        else
            return s[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/lpc_synth_if.sv
// Frame-load, sample-request and sample-output bundle of the LPC synthesis stage.
interface lpc_synth_if;
    import lpc_pkg::*;

    logic                      frame_v;
    logic [DATA_W*ORDER-1:0]   coef;
    logic                      voiced;
    logic [15:0]               pitch;
    logic [DATA_W-1:0]         gain;
    logic                      tick;
    logic signed [DATA_W-1:0]  y;
    logic                      vout;
    logic                      overrun;

    modport master (output frame_v, coef, voiced, pitch, gain, tick,
                    input  y, vout, overrun);
    modport slave  (input  frame_v, coef, voiced, pitch, gain, tick,
                    output y, vout, overrun);
endinterface

// File: rtl/lpc_excitation.sv
// Excitation source: pitch impulse train for voiced frames, LFSR noise otherwise.
// LPC_SYNTH_NOISE_EN builds the noise generator; without it unvoiced excitation is zero.
module lpc_excitation
    import lpc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     advance,
    input  logic                     voiced,
    input  logic [15:0]              pitch,
    input  logic [DATA_W-1:0]        gain,
    output logic signed [DATA_W:0]   e
);
    logic [15:0]             pcnt_q, pcnt_d;
    logic                    use_pulse;
    logic signed [DATA_W:0]  noise;

    assign use_pulse = voiced && (pitch != 16'd0);

    // Phase is only advanced by pulse frames so it carries across voiced frame changes.
    always_comb begin
        pcnt_d = pcnt_q;
        if (advance && use_pulse)
            pcnt_d = (pcnt_q >= pitch - 16'd1) ? 16'd0 : pcnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt_q <= '0;
        else
            pcnt_q <= pcnt_d;
    end

`ifdef LPC_SYNTH_NOISE_EN
    logic [15:0]            lfsr_q, lfsr_d;
    logic signed [DATA_W:0] mag;

    assign mag   = {1'b0, gain >> 2};
    assign noise = lfsr_q[0] ? -mag : mag;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance && !use_pulse)
            lfsr_d = {^(lfsr_q & LFSR_TAP_MASK), lfsr_q[15:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= lfsr_d;
    end
`else
    assign noise = '0;
`endif

    assign e = use_pulse ? ((pcnt_q == 16'd0) ? {1'b0, gain} : '0) : noise;
endmodule

// File: rtl/lpc_synth.sv
// LPC synthesis: excitation through a 10th-order all-pole filter on one time-shared MAC.
// Noise excitation for unvoiced frames is built only with LPC_SYNTH_NOISE_EN.
module lpc_synth
    import lpc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    lpc_synth_if.slave  bus
);
    state_e                    state_q, state_d;
    logic [K_W-1:0]            k_q, k_d, k_idx;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  y_q, y_d;
    logic                      vout_q, vout_d, overrun_q, overrun_d;
    logic                      pend_flag_q, pend_flag_d;
    logic signed [DATA_W-1:0]  coef_act_q [ORDER], coef_act_d [ORDER];
    logic signed [DATA_W-1:0]  coef_pnd_q [ORDER], coef_pnd_d [ORDER];
    logic signed [DATA_W-1:0]  hist_q [ORDER], hist_d [ORDER];
    logic signed [DATA_W-1:0]  coef_in [ORDER];
    logic                      voiced_act_q, voiced_act_d, voiced_pnd_q, voiced_pnd_d;
    logic [15:0]               pitch_act_q, pitch_act_d, pitch_pnd_q, pitch_pnd_d;
    logic [DATA_W-1:0]         gain_act_q, gain_act_d, gain_pnd_q, gain_pnd_d;
    logic                      accept, commit;
    logic signed [DATA_W:0]    e;
    logic signed [2*DATA_W-1:0] prod;

    genvar gi;
    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_coef
            assign coef_in[gi] = bus.coef[DATA_W*gi +: DATA_W];
        end
    endgenerate

    assign accept = bus.tick && (state_q == IDLE);
    // Never swap coefficients under a running or just-requested sample.
    assign commit = (state_q == IDLE) && !bus.tick && pend_flag_q;

    lpc_excitation u_exc (
        .clk     (clk),
        .rst     (rst),
        .advance (accept),
        .voiced  (voiced_act_q),
        .pitch   (pitch_act_q),
        .gain    (gain_act_q),
        .e       (e)
    );

    assign k_idx = (k_q >= K_W'(1) && k_q <= K_W'(ORDER)) ? k_q - K_W'(1) : '0;
    assign prod  = coef_act_q[k_idx] * hist_q[k_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.tick) state_d = MAC;
            MAC:     if (k_q == K_W'(ORDER)) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        k_d          = k_q;
        acc_d        = acc_q;
        y_d          = y_q;
        vout_d       = 1'b0;
        overrun_d    = overrun_q | (bus.tick && state_q != IDLE);
        hist_d       = hist_q;
        coef_act_d   = coef_act_q;
        coef_pnd_d   = coef_pnd_q;
        voiced_act_d = voiced_act_q;
        voiced_pnd_d = voiced_pnd_q;
        pitch_act_d  = pitch_act_q;
        pitch_pnd_d  = pitch_pnd_q;
        gain_act_d   = gain_act_q;
        gain_pnd_d   = gain_pnd_q;
        pend_flag_d  = pend_flag_q;

        case (state_q)
            IDLE: if (accept) begin
                acc_d = {{(ACC_W-DATA_W-1-FRAC){e[DATA_W]}}, e, {FRAC{1'b0}}};
                k_d   = K_W'(1);
            end
            MAC: begin
                acc_d = acc_q - {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
                k_d   = k_q + K_W'(1);
            end
            OUT: begin
                y_d       = sat_shift(acc_q);
                vout_d    = 1'b1;
                hist_d[0] = y_d;
                for (int i = 1; i < ORDER; i++)
                    hist_d[i] = hist_q[i-1];
                k_d       = '0;
            end
            default: ;
        endcase

        if (commit) begin
            coef_act_d   = coef_pnd_q;
            voiced_act_d = voiced_pnd_q;
            pitch_act_d  = pitch_pnd_q;
            gain_act_d   = gain_pnd_q;
            pend_flag_d  = 1'b0;
        end
        // A new frame arriving on the commit edge stays pending for the next one.
        if (bus.frame_v) begin
            coef_pnd_d   = coef_in;
            voiced_pnd_d = bus.voiced;
            pitch_pnd_d  = bus.pitch;
            gain_pnd_d   = bus.gain;
            pend_flag_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q          <= '0;
            acc_q        <= '0;
            y_q          <= '0;
            vout_q       <= 1'b0;
            overrun_q    <= 1'b0;
            pend_flag_q  <= 1'b0;
            voiced_act_q <= 1'b0;
            voiced_pnd_q <= 1'b0;
            pitch_act_q  <= '0;
            pitch_pnd_q  <= '0;
            gain_act_q   <= '0;
            gain_pnd_q   <= '0;
            for (int i = 0; i < ORDER; i++) begin
                hist_q[i]     <= '0;
                coef_act_q[i] <= '0;
                coef_pnd_q[i] <= '0;
            end
        end else begin
            k_q          <= k_d;
            acc_q        <= acc_d;
            y_q          <= y_d;
            vout_q       <= vout_d;
            overrun_q    <= overrun_d;
            pend_flag_q  <= pend_flag_d;
            voiced_act_q <= voiced_act_d;
            voiced_pnd_q <= voiced_pnd_d;
            pitch_act_q  <= pitch_act_d;
            pitch_pnd_q  <= pitch_pnd_d;
            gain_act_q   <= gain_act_d;
            gain_pnd_q   <= gain_pnd_d;
            hist_q       <= hist_d;
            coef_act_q   <= coef_act_d;
            coef_pnd_q   <= coef_pnd_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.vout    = vout_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_lpc_synth.sv
// Directed bench for lpc_synth: vector table of single-tick samples plus multi-cycle sequences.
// Noise expectations follow LPC_SYNTH_NOISE_EN.
module tb_lpc_synth;
    import lpc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    lpc_synth_if bus ();

    lpc_synth dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                  do_rst;
        bit                  do_frame;
        logic signed [15:0]  a1;
        logic signed [15:0]  a2;
        bit                  voiced;
        logic [15:0]         pitch;
        logic [15:0]         gain;
        logic signed [15:0]  exp_y;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(bit r, bit f, int a1, int a2, bit v, int p, int g, int ey);
        vec_t t;
        t.do_rst = r; t.do_frame = f; t.a1 = 16'(a1); t.a2 = 16'(a2);
        t.voiced = v; t.pitch = 16'(p); t.gain = 16'(g); t.exp_y = 16'(ey);
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic set_frame(input int a1, input int a2, input bit v, input int p, input int g);
        bus.coef        = '0;
        bus.coef[15:0]  = 16'(a1);
        bus.coef[31:16] = 16'(a2);
        bus.voiced      = v;
        bus.pitch       = 16'(p);
        bus.gain        = 16'(g);
    endtask

    task automatic pulse_frame();
        @(negedge clk); bus.frame_v = 1'b1;
        @(negedge clk); bus.frame_v = 1'b0;
    endtask

    // One tick sampled at E0; optional frame_v / extra tick sampled at E0+fv_at / E0+t2_at.
    task automatic run_sample(input int fv_at, input int t2_at,
                              output int lat, output int nv, output logic signed [15:0] yv);
        lat = -1; nv = 0; yv = '0;
        @(negedge clk);
        bus.tick    = 1'b1;
        bus.frame_v = (fv_at == 0);
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            bus.tick    = (t2_at == c + 1);
            bus.frame_v = (fv_at == c + 1);
            if (bus.vout) begin
                nv++;
                if (lat < 0) begin
                    lat = c;
                    yv  = bus.y;
                end
            end
        end
        bus.tick    = 1'b0;
        bus.frame_v = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nv, quiet_vouts;
        logic signed [15:0] yv;
        logic [15:0] lfsr_m;
        logic fb;
        int exp_n;

        rst = 1'b1;
        bus.tick = 1'b0; bus.frame_v = 1'b0;
        set_frame(0, 0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_y", bus.y, 0);
        chk("reset_vout", bus.vout, 0);
        chk("reset_overrun", bus.overrun, 0);
        rst = 1'b0;

        // impulse train
        tbl.push_back(mkv(1, 1, 0, 0, 1, 5, 1000, 1000));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 5, 1000, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 5, 1000, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 5, 1000, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 5, 1000, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 5, 1000, 1000));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 5, 1000, 0));
        // one-pole decay
        tbl.push_back(mkv(1, 1, -2048, 0, 1, 100, 4096, 4096));
        tbl.push_back(mkv(0, 0, -2048, 0, 1, 100, 4096, 2048));
        tbl.push_back(mkv(0, 0, -2048, 0, 1, 100, 4096, 1024));
        tbl.push_back(mkv(0, 0, -2048, 0, 1, 100, 4096, 512));
        tbl.push_back(mkv(0, 0, -2048, 0, 1, 100, 4096, 256));
        // saturation
        tbl.push_back(mkv(1, 1, -4096, 0, 1, 1, 30000, 30000));
        tbl.push_back(mkv(0, 0, -4096, 0, 1, 1, 30000, 32767));
        tbl.push_back(mkv(0, 0, -4096, 0, 1, 1, 30000, 32767));
        // second tap: y[n] = e[n] + y[n-2]
        tbl.push_back(mkv(1, 1, 0, -4096, 1, 3, 100, 100));
        tbl.push_back(mkv(0, 0, 0, -4096, 1, 3, 100, 0));
        tbl.push_back(mkv(0, 0, 0, -4096, 1, 3, 100, 100));
        tbl.push_back(mkv(0, 0, 0, -4096, 1, 3, 100, 100));
        tbl.push_back(mkv(0, 0, 0, -4096, 1, 3, 100, 100));
        // alternating sign, floor rounding: y = e - 0.5*y1
        tbl.push_back(mkv(1, 1, 2048, 0, 1, 100, 3, 3));
        tbl.push_back(mkv(0, 0, 2048, 0, 1, 100, 3, -2));
        tbl.push_back(mkv(0, 0, 2048, 0, 1, 100, 3, 1));
        tbl.push_back(mkv(0, 0, 2048, 0, 1, 100, 3, -1));
        tbl.push_back(mkv(0, 0, 2048, 0, 1, 100, 3, 0));

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            if (tbl[i].do_frame) begin
                set_frame(tbl[i].a1, tbl[i].a2, tbl[i].voiced, tbl[i].pitch, tbl[i].gain);
                pulse_frame();
            end
            run_sample(-1, -1, lat, nv, yv);
            chk($sformatf("vec%0d_y", i), yv, tbl[i].exp_y);
            chk($sformatf("vec%0d_latency", i), lat, 11);
            chk($sformatf("vec%0d_vout_count", i), nv, 1);
            $display("vec %0d: y=%0d expected=%0d latency=%0d", i, yv, tbl[i].exp_y, lat);
        end

        // reset in the middle of MAC
        do_reset();
        set_frame(-2048, 0, 1'b1, 100, 4096);
        pulse_frame();
        run_sample(-1, -1, lat, nv, yv);
        chk("midrst_pre_y", yv, 4096);
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0;
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0;
        chk("midrst_pre_overrun", bus.overrun, 1);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("midrst_y", bus.y, 0);
        chk("midrst_vout", bus.vout, 0);
        chk("midrst_overrun", bus.overrun, 0);
        @(negedge clk); rst = 1'b0;
        quiet_vouts = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.vout) quiet_vouts++;
        end
        chk("midrst_no_vout", quiet_vouts, 0);
        set_frame(0, 0, 1'b1, 100, 0);
        pulse_frame();
        run_sample(-1, -1, lat, nv, yv);
        chk("midrst_post_y", yv, 0);
        chk("midrst_post_latency", lat, 11);
        $display("midrst: post y=%0d latency=%0d", yv, lat);

        // overrun: second tick at E0+5
        do_reset();
        set_frame(0, 0, 1'b1, 1, 500);
        pulse_frame();
        run_sample(-1, 5, lat, nv, yv);
        chk("ovr5_vout_count", nv, 1);
        chk("ovr5_y", yv, 500);
        chk("ovr5_overrun", bus.overrun, 1);
        run_sample(-1, -1, lat, nv, yv);
        chk("ovr_sticky", bus.overrun, 1);
        chk("ovr_next_y", yv, 500);
        do_reset();
        chk("ovr_cleared", bus.overrun, 0);
        $display("overrun E0+5: vouts=%0d y=%0d", nv, yv);
        // boundary: tick at E0+11 (OUT) is dropped
        pulse_frame();
        run_sample(-1, 11, lat, nv, yv);
        chk("ovr11_vout_count", nv, 1);
        chk("ovr11_overrun", bus.overrun, 1);
        // boundary: tick at E0+12 is the minimum legal spacing
        do_reset();
        pulse_frame();
        run_sample(-1, 12, lat, nv, yv);
        chk("sp12_vout_count", nv, 2);
        chk("sp12_overrun", bus.overrun, 0);
        $display("spacing 12: vouts=%0d overrun=%0d", nv, bus.overrun);

        // frame commit timing
        do_reset();
        set_frame(-2048, 0, 1'b1, 100, 4096);
        pulse_frame();
        run_sample(-1, -1, lat, nv, yv);
        chk("commit_s1_y", yv, 4096);
        set_frame(0, 0, 1'b1, 100, 4096);
        run_sample(3, -1, lat, nv, yv);
        chk("commit_s2_old_coef_y", yv, 2048);
        run_sample(-1, -1, lat, nv, yv);
        chk("commit_s3_new_coef_y", yv, 0);
        set_frame(-4096, 0, 1'b1, 1, 100);
        run_sample(0, -1, lat, nv, yv);
        chk("commit_s4_same_edge_y", yv, 0);
        run_sample(-1, -1, lat, nv, yv);
        chk("commit_s5_y", yv, 0);
        run_sample(-1, -1, lat, nv, yv);
        chk("commit_s6_y", yv, 100);
        $display("commit: s6 y=%0d", yv);

        // noise excitation: unvoiced, then voiced with pitch 0
        do_reset();
        set_frame(0, 0, 1'b0, 5, 4000);
        pulse_frame();
        lfsr_m = 16'hACE1;
        for (int n = 0; n < 8; n++) begin
            if (n == 6) begin
                set_frame(0, 0, 1'b1, 0, 4000);
                pulse_frame();
            end
`ifdef LPC_SYNTH_NOISE_EN
            exp_n  = lfsr_m[0] ? -1000 : 1000;
            fb     = lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5];
            lfsr_m = {fb, lfsr_m[15:1]};
`else
            exp_n  = 0;
`endif
            run_sample(-1, -1, lat, nv, yv);
            chk($sformatf("noise%0d_y", n), yv, exp_n);
            $display("noise %0d: y=%0d expected=%0d", n, yv, exp_n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lpc_synth.md
# lpc_synth

LPC synthesis (decode) stage directly downstream of the LPC encoder. Each sample tick, it builds an excitation sample: a pitch impulse train for voiced frames, or LFSR noise for unvoiced frames. It passes that sample through a 10th-order all-pole filter using the encoder's A1..A10 predictor coefficients and emits one 16-bit speech sample per tick. It uses a single serial MAC and time-shares it over the taps.

## Interface
- ORDER, 10, predictor order; number of taps used (A0 is implied 1.0 and has no port)
- DATA_W, 16, sample, coefficient and gain width
- FRAC, 12, fractional bits of the signed coefficients (Q3.12)
- ACC_W, 40, accumulator width
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- frame_v  in  1  one-cycle strobe; latch coef/voiced/pitch/gain as the next frame
- coef  in  DATA_W*ORDER  flattened signed A1..A10; A_k = coef[DATA_W*k-1 : DATA_W*(k-1)]
- voiced  in  1  1 = voiced frame, 0 = unvoiced frame
- pitch  in  16  pitch period in samples (encoder freq_count); 0 = treat frame as unvoiced
- gain  in  DATA_W  unsigned excitation amplitude
- tick  in  1  one-cycle sample request
- y  out  DATA_W  signed synthesized sample
- vout  out  1  one-cycle strobe; y is valid while vout is high
- overrun  out  1  sticky; a tick arrived while the block was busy

## Operation
- FSM states:
  - IDLE: accepted tick → MAC with k=1, and acc = e <<< FRAC.
  - MAC: each cycle acc -= A_k*h_k and k++; after k=ORDER → OUT.
  - OUT: y ← sat(acc >>> FRAC), vout=1, history shifts (h_1 ← y), then → IDLE.
- Products are DATA_W×DATA_W signed (32 bit), sign-extended to ACC_W.
- acc >>> FRAC is an arithmetic shift (floor). The result saturates to [-32768, 32767].
- History h_1..h_ORDER holds saturated outputs; all are 0 after reset.
- Frame registers are double-buffered:
  - frame_v writes a pending set and sets pend_flag.
  - The pending set commits to the active set on an edge where state==IDLE and no tick is accepted.
  - A second frame_v before commit overwrites the pending set (latest wins).
- Excitation (computed on the accepting edge from the active set):
  - Voiced with pitch≠0: e = gain when pcnt==0, else 0. pcnt advances per accepted tick and wraps to 0 when pcnt >= pitch-1.
  - pcnt is not cleared on frame commit, so phase continues across frames.
  - Unvoiced, or pitch==0: e = lfsr[0] ? -(gain>>2) : +(gain>>2). The 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances per accepted tick.
- A tick while state≠IDLE is dropped and sets overrun. overrun clears only on rst.
- Reset values:
  - y=0, vout=0, overrun=0, state=IDLE, k=0, acc=0, pcnt=0, lfsr=16'hACE1.
  - Active and pending sets are all zero; pend_flag=0.
- Reset mid-operation aborts the sample with no vout.

## Timing
- tick is sampled at edge E0. MAC runs at E1..E10, OUT at E11. y/vout update at E11, so vout is high for the cycle after E11.
- Latency is 11 clocks from tick to vout; y holds until the next OUT.
- Minimum tick spacing is 12 clocks; a tick at E0+11 (state OUT) is an overrun.
- Coefficients are stable for a whole sample: commit never occurs during MAC/OUT or on a tick edge.
- tick and frame_v on the same IDLE edge: the sample uses the old set; the new set commits on the next idle non-tick edge.

## Configuration
- LPC_SYNTH_NOISE_EN defined: unvoiced/pitch==0 frames use LFSR noise excitation as above.
- Undefined: no LFSR is built; unvoiced excitation is 0 (silence plus filter ringing of history).

## Structure
- Shared package lpc_pkg holds:
  - ORDER, DATA_W, FRAC, ACC_W;
  - LFSR_SEED and tap constants;
  - saturation limits;
  - the FSM state enum (IDLE, MAC, OUT).
- One sub-module, lpc_excitation, holds the pitch counter, the LFSR and the e mux. It has inputs advance/voiced/pitch/gain and output e.
- MAC, history and FSM stay in lpc_synth.

## Test plan
- Reset: assert rst mid-MAC → y=0, vout=0, overrun=0; next tick with zero coefs and gain → y=0.
- Impulse train: coefs 0, voiced, pitch=5, gain=1000, tick every 16 clocks → y = 1000,0,0,0,0,1000,…; vout 11 clocks after each tick.
- One-pole decay: A1=-2048, others 0, voiced, pitch=100, gain=4096 → y = 4096, 2048, 1024, 512, 256.
- Saturation: A1=-4096, voiced, pitch=1, gain=30000 → y = 30000, 32767, 32767.
- Overrun and commit:
  - Ticks at E0 and E0+5 → exactly one vout; overrun=1 until rst.
  - frame_v at E0+3 with new coefs → current sample uses old coefs; the next sample uses new ones.
- Noise: coefs 0, voiced=0, gain=4000 → y ∈ {+1000, -1000} following the lfsr[0] sequence from seed ACE1. With LPC_SYNTH_NOISE_EN undefined → y=0.
